ahb_rr_arbiter: RTL
===================

// Module: ahb_rr_arbiter
// PURPOSE
//  Round-robin AHB bus arbiter for NUM_MASTERS masters sharing one address/data path.
//  It grants the bus on burst boundaries and tracks burst length from hburst/htrans.
//  It honours hlock and parks the bus on DEFAULT_MASTER when idle.
//  hgrant drives the masters; hmaster drives the address/write-data muxes.
// PARAMETERS
//  NUM_MASTERS     3   number of requesting masters (2..8)
//  DEFAULT_MASTER  0   park master index when no requests
//  MAX_HOLD        16  max beats per tenure for INCR/undefined bursts before forced re-arbitration
// PORTS
//  hclk       in   1            bus clock, rising edge
//  hresetn    in   1            asynchronous active-low reset
//  hbusreq    in   NUM_MASTERS  bus request, one bit per master
//  hlock      in   NUM_MASTERS  locked-transfer request, one bit per master
//  htrans     in   2            transfer type of current owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//  hburst     in   3            burst type of current owner (AHB encoding)
//  hready     in   1            bus ready from selected slave
//  hresp      in   1            error response from selected slave (1 = ERROR)
//  hgrant     out  NUM_MASTERS  one-hot grant
//  hmaster    out  MW           MW=$clog2(NUM_MASTERS); address-phase owner index
//  hmastlock  out  1            current address-phase transfer is locked
// BEHAVIOUR
//  Reset (async, hresetn=0):
//   - hgrant=onehot(DEFAULT_MASTER), hmaster=DEFAULT_MASTER, hmastlock=0.
//   - rr pointer=DEFAULT_MASTER, beats_left=0, state=PARK.
//  States:
//   - PARK: no request; default master granted.
//   - OWN: granted master holds an unlocked tenure.
//   - LOCK: granted master holds a locked tenure.
//  Winner search: first requester in hbusreq starting at (pointer+1) mod NUM_MASTERS, wrapping.
//   On grant, pointer is set to the winner. Winner == current owner is allowed.
//  Arbitration point (AP): hready=1, state!=LOCK, and one of:
//   - beats_left==0, or
//   - owner hbusreq=0 with htrans=IDLE, or
//   - error termination (below).
//  At AP: hgrant<=onehot(winner) on the next edge; state<=LOCK if hlock[winner], else OWN.
//   If no requester: hgrant<=onehot(DEFAULT_MASTER) and state<=PARK.
//  Burst tracking (only when hready=1):
//   - NONSEQ loads beats_left = burst length minus 1.
//     Lengths: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=MAX_HOLD.
//   - SEQ decrements beats_left, saturating at 0.
//   - BUSY and IDLE hold beats_left.
//  LOCK exits at the first cycle with hready=1 and owner hlock=0 and hbusreq=0, or owner hlock=0 and beats_left==0.
//   That cycle counts as an AP.
//  Error: first cycle of hresp=1 with hready=0 clears beats_left to 0 and forces an AP on the next hready=1.
//   This applies in LOCK as well.
//  hmaster/hmastlock latency:
//   - update on the edge where hready=1, taking the hgrant index and the lock state.
//   - i.e. one address phase after the grant change.
//   - hold while hready=0.
//  hgrant is always exactly one-hot, never all-zero. hgrant changes only at an AP.
//  A request drop mid-burst does not revoke the grant before beats_left==0.
//   The exception is error termination.
//  Simultaneous requests at an AP: round-robin order decides; no master is starved beyond NUM_MASTERS-1 tenures.
//  Reset mid-burst: outputs take reset values immediately; no residual beat count.
// TESTING
//  - Reset, no requests -> hgrant=3'b001, hmaster=0, hmastlock=0, held for 10 cycles.
//  - hbusreq=3'b111 held, SINGLE NONSEQ each tenure, hready=1
//    -> grants rotate 1,2,0,1 (pointer starts at 0); hmaster lags hgrant by 1 cycle.
//  - M1 INCR4 (NONSEQ+3 SEQ), M2 requests at beat 2 -> hgrant stays 3'b010 until beats_left==0, then 3'b100.
//  - M2 hlock=1 with INCR8 and hready low 2 cycles mid-burst; M0 requests
//    -> hmastlock=1 for all 8 beats, no grant change, M0 granted only after hlock drops.
//  - M0 INCR with MAX_HOLD=4, M1 requesting -> grant moves to M1 after 4 beats.
//  - Error on beat 2 of INCR8 (hresp=1, hready=0 then hresp=1, hready=1) -> re-arbitration on the hready=1 cycle.
//  - hresetn low during an INCR16 beat 5 -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_rr_arbiter_if.sv
// Arbitration bus bundle: requests and transfer status from the masters/slave,
// and grant/owner information back from the arbiter.
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 3
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic                   hresp;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic                   hmastlock;

  // master: the requesting side of the bus; slave: the arbiter itself
  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: re-arbitrates on burst boundaries, honours locked
// tenures, parks on DEFAULT_MASTER and forces re-arbitration after an ERROR.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  ahb_rr_arbiter_if.slave   bus
);
  localparam int MW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int MAXLEN = (MAX_HOLD > 16) ? MAX_HOLD : 16;
  localparam int BW     = $clog2(MAXLEN + 1);
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_LOCK} state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] grant_idx_q, grant_idx_d;
  logic [MW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] beats_q, beats_d;
  logic          err_q, err_d;
  logic [MW-1:0] hmaster_q;
  logic          hmastlock_q;

  logic          found;
  logic [MW-1:0] winner;
  logic [MW-1:0] cand;
  logic          owner_req;
  logic          owner_lock;
  logic          ap;

  // Beats remaining after the NONSEQ beat, by AHB hburst encoding
  function automatic logic [BW-1:0] burst_last(input logic [2:0] b);
    case (b)
      3'b000:         burst_last = '0;
      3'b001:         burst_last = BW'(MAX_HOLD - 1);
      3'b010, 3'b011: burst_last = BW'(3);
      3'b100, 3'b101: burst_last = BW'(7);
      default:        burst_last = BW'(15);
    endcase
  endfunction

  assign owner_req  = bus.hbusreq[grant_idx_q];
  assign owner_lock = bus.hlock[grant_idx_q];

  // First requester after the pointer, wrapping; the pointer itself is checked last
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(ptr_q) + i) % NUM_MASTERS);
      if (!found && bus.hbusreq[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    ap = 1'b0;
    if (bus.hready) begin
      if (state_q == ST_LOCK)
        ap = err_q || (!owner_lock && (!owner_req || beats_q == '0));
      else
        ap = err_q || (beats_q == '0) || (!owner_req && bus.htrans == HT_IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    beats_d     = beats_q;
    err_d       = err_q;

    if (ap) begin
      err_d = 1'b0;
      if (found) begin
        grant_idx_d = winner;
        ptr_d       = winner;
        state_d     = bus.hlock[winner] ? ST_LOCK : ST_OWN;
      end else begin
        grant_idx_d = DEF_IDX;
        state_d     = ST_PARK;
      end
    end

    // An ERROR's first (wait) cycle ends the burst; the next ready cycle re-arbitrates
    if (bus.hresp && !bus.hready) begin
      beats_d = '0;
      err_d   = 1'b1;
    end else if (bus.hready) begin
      case (bus.htrans)
        HT_NONSEQ: beats_d = burst_last(bus.hburst);
        HT_SEQ:    beats_d = (beats_q == '0) ? '0 : beats_q - 1'b1;
        default:   beats_d = beats_q;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_PARK;
      grant_idx_q <= DEF_IDX;
      ptr_q       <= DEF_IDX;
      beats_q     <= '0;
      err_q       <= 1'b0;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      beats_q     <= beats_d;
      err_q       <= err_d;
      // Address-phase owner follows the grant one accepted transfer later
      if (bus.hready) begin
        hmaster_q   <= grant_idx_q;
        hmastlock_q <= (state_q == ST_LOCK);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
      assign bus.hgrant[gi] = (grant_idx_q == MW'(gi));
    end
  endgenerate

  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

endmodule
